// File: rtl/ddr_load_gather.sv
// Purpose: queue warp load requests, gather returned DDR line beats into per-lane words, emit one packet per request in order.
// Latency: packet valid one cycle after the beat that completes the head request; a zero-mask head completes in its first cycle.
// Backpressure: stall_i holds a valid packet and freezes gather (line_ready_o low); req_ready_o drops when the request queue is full.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   load_i / req_ready_o            request push strobe / queue not full
//   InfoRamAddr_i, lane_mask_i      per-lane byte addresses and active-lane mask of the request
//   RAM2DDR3_ldstWarp_i/Reg_i       warp id and destination register of the request
//   rdy, line_addr_i, dout_i        returned line beat (valid, byte address, data)
//   line_ready_o                    beats are accepted this cycle
//   stall_i                         downstream stall
//   loadPacketValid_o, loadWarp_o,
//   loadMask_o, loadPacket_o        outgoing load packet, lane i = {reg, data32}
//   drop_err_o                      sticky: a beat arrived while line_ready_o was low
module ddr_load_gather #(
    parameter int NUM_LANES  = 32,
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 64,
    parameter int WARP_W     = 2,
    parameter int REG_W      = 5,
    parameter int REQ_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              load_i,
    output logic                              req_ready_o,
    input  logic [NUM_LANES*ADDR_W-1:0]       InfoRamAddr_i,
    input  logic [NUM_LANES-1:0]              lane_mask_i,
    input  logic [WARP_W-1:0]                 RAM2DDR3_ldstWarp_i,
    input  logic [REG_W-1:0]                  RAM2DDR3_ldstReg_i,
    input  logic                              rdy,
    input  logic [ADDR_W-1:0]                 line_addr_i,
    input  logic [8*LINE_BYTES-1:0]           dout_i,
    output logic                              line_ready_o,
    input  logic                              stall_i,
    output logic                              loadPacketValid_o,
    output logic [WARP_W-1:0]                 loadWarp_o,
    output logic [NUM_LANES-1:0]              loadMask_o,
    output logic [NUM_LANES*(REG_W+32)-1:0]   loadPacket_o,
    output logic                              drop_err_o
);

    localparam int OFF    = $clog2(LINE_BYTES);
    localparam int PTR_W  = $clog2(REQ_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LANE_W = REG_W + 32;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(REQ_DEPTH);

    // Request queue storage (datapath only, never reset)
    logic [NUM_LANES*ADDR_W-1:0] q_addr [REQ_DEPTH];
    logic [NUM_LANES-1:0]        q_mask [REQ_DEPTH];
    logic [WARP_W-1:0]           q_warp [REQ_DEPTH];
    logic [REG_W-1:0]            q_reg  [REQ_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Gather state for the head request
    logic [NUM_LANES-1:0] done;
    logic [31:0]          acc    [NUM_LANES];
    logic [31:0]          lane_word [NUM_LANES];
    logic [31:0]          merged [NUM_LANES];

    logic [NUM_LANES*ADDR_W-1:0] head_addr;
    logic [NUM_LANES-1:0]        head_mask;
    logic [WARP_W-1:0]           head_warp;
    logic [REG_W-1:0]            head_reg;

    logic                 head_valid;
    logic                 out_free;
    logic                 beat_acc;
    logic                 push;
    logic                 complete;
    logic [NUM_LANES-1:0] pending;
    logic [NUM_LANES-1:0] hit;
    logic [NUM_LANES-1:0] hit_acc;

    logic unused_line_low;
    assign unused_line_low = ^line_addr_i[OFF-1:0];

    assign head_addr = q_addr[rd_ptr];
    assign head_mask = q_mask[rd_ptr];
    assign head_warp = q_warp[rd_ptr];
    assign head_reg  = q_reg[rd_ptr];

    assign head_valid   = (count != '0);
    assign req_ready_o  = (count != DEPTH_C);
    assign out_free     = !(loadPacketValid_o && stall_i);
    assign line_ready_o = head_valid && out_free;
    assign beat_acc     = rdy && line_ready_o;
    assign push         = load_i && req_ready_o;
    assign pending      = head_mask & ~done;
    assign hit_acc      = beat_acc ? hit : '0;
    // Head is finished once every lane still pending is satisfied by this cycle's beat
    assign complete     = head_valid && out_free && ((pending & ~hit_acc) == '0);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [ADDR_W-1:0] lane_addr;
        logic [OFF-3:0]    widx;
        logic              unused_low;

        assign lane_addr    = head_addr[g*ADDR_W +: ADDR_W];
        assign widx         = lane_addr[OFF-1:2];
        assign unused_low   = ^lane_addr[1:0];
        assign hit[g]       = pending[g] && (lane_addr[ADDR_W-1:OFF] == line_addr_i[ADDR_W-1:OFF]);
        assign lane_word[g] = dout_i[32*widx +: 32];
        // Current beat wins so the final beat's data lands in the packet on the same edge
        assign merged[g]    = hit_acc[g] ? lane_word[g] : acc[g];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= InfoRamAddr_i;
            q_mask[wr_ptr] <= lane_mask_i;
            q_warp[wr_ptr] <= RAM2DDR3_ldstWarp_i;
            q_reg[wr_ptr]  <= RAM2DDR3_ldstReg_i;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (hit_acc[i]) begin
                acc[i] <= lane_word[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            done              <= '0;
            loadPacketValid_o <= 1'b0;
            loadWarp_o        <= '0;
            loadMask_o        <= '0;
            loadPacket_o      <= '0;
            drop_err_o        <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (complete) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !complete) begin
                count <= count + 1'b1;
            end else if (!push && complete) begin
                count <= count - 1'b1;
            end

            if (complete) begin
                done <= '0;
            end else if (beat_acc) begin
                done <= done | hit;
            end

            // While stalled the valid packet is held; otherwise valid tracks completion
            if (out_free) begin
                loadPacketValid_o <= complete;
            end
            if (complete) begin
                loadWarp_o <= head_warp;
                loadMask_o <= head_mask;
                for (int i = 0; i < NUM_LANES; i++) begin
                    loadPacket_o[i*LANE_W +: LANE_W] <= {head_reg, head_mask[i] ? merged[i] : 32'd0};
                end
            end

            if (rdy && !line_ready_o) begin
                drop_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_load_gather.sv
module tb_ddr_load_gather;

    localparam int NL     = 32;
    localparam int AW     = 32;
    localparam int LB     = 64;
    localparam int LINE_W = 8*LB;
    localparam int WW     = 2;
    localparam int RW     = 5;
    localparam int LANE_W = RW + 32;
    localparam int N_RND  = 300;
    localparam int BUDGET = 20000;
    localparam logic [31:0] POOL = 32'h1000_0000;

    logic                 clk;
    logic                 reset;
    logic                 load_i;
    logic                 req_ready_o;
    logic [NL*AW-1:0]     InfoRamAddr_i;
    logic [NL-1:0]        lane_mask_i;
    logic [WW-1:0]        RAM2DDR3_ldstWarp_i;
    logic [RW-1:0]        RAM2DDR3_ldstReg_i;
    logic                 rdy;
    logic [AW-1:0]        line_addr_i;
    logic [LINE_W-1:0]    dout_i;
    logic                 line_ready_o;
    logic                 stall_i;
    logic                 loadPacketValid_o;
    logic [WW-1:0]        loadWarp_o;
    logic [NL-1:0]        loadMask_o;
    logic [NL*LANE_W-1:0] loadPacket_o;
    logic                 drop_err_o;

    ddr_load_gather dut (
        .clk                 (clk),
        .reset               (reset),
        .load_i              (load_i),
        .req_ready_o         (req_ready_o),
        .InfoRamAddr_i       (InfoRamAddr_i),
        .lane_mask_i         (lane_mask_i),
        .RAM2DDR3_ldstWarp_i (RAM2DDR3_ldstWarp_i),
        .RAM2DDR3_ldstReg_i  (RAM2DDR3_ldstReg_i),
        .rdy                 (rdy),
        .line_addr_i         (line_addr_i),
        .dout_i              (dout_i),
        .line_ready_o        (line_ready_o),
        .stall_i             (stall_i),
        .loadPacketValid_o   (loadPacketValid_o),
        .loadWarp_o          (loadWarp_o),
        .loadMask_o          (loadMask_o),
        .loadPacket_o        (loadPacket_o),
        .drop_err_o          (drop_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        logic [NL*AW-1:0] addrs;
        logic [NL-1:0]    mask;
        logic [WW-1:0]    warp;
        logic [RW-1:0]    rg;
    } req_t;

    req_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Reference memory: every 32-bit word has a fixed value derived from its address
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] ln;
        logic [31:0] k;
        ln = addr >> 6;
        k  = {28'd0, addr[5:2]};
        return (ln * 32'h9E3779B1) ^ (k * 32'h01010101) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [LINE_W-1:0] line_data(input logic [31:0] base);
        logic [LINE_W-1:0] d;
        logic [31:0]       b;
        b = {base[31:6], 6'd0};
        for (int k = 0; k < 16; k++) d[32*k +: 32] = mem_word(b + 32'(4*k));
        return d;
    endfunction

    function automatic logic [LANE_W-1:0] lane(input int i);
        return loadPacket_o[i*LANE_W +: LANE_W];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pkt(input string tag, input logic [WW-1:0] warp, input logic [NL-1:0] mask,
                             input logic [RW-1:0] rg, input logic [31:0] d [NL]);
        check({tag, "_valid"}, 64'(loadPacketValid_o), 64'd1);
        check({tag, "_warp"},  64'(loadWarp_o), 64'(warp));
        check({tag, "_mask"},  64'(loadMask_o), 64'(mask));
        for (int i = 0; i < NL; i++)
            check($sformatf("%s_lane%0d", tag, i), 64'(lane(i)), 64'({rg, mask[i] ? d[i] : 32'd0}));
    endtask

    task automatic do_reset();
        reset = 1'b1; load_i = 1'b0; rdy = 1'b0; stall_i = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    task automatic send_req(input logic [NL*AW-1:0] a, input logic [NL-1:0] m,
                            input logic [WW-1:0] w, input logic [RW-1:0] r);
        InfoRamAddr_i = a; lane_mask_i = m; RAM2DDR3_ldstWarp_i = w; RAM2DDR3_ldstReg_i = r;
        load_i = 1'b1;
        cyc();
        load_i = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] la, input logic [LINE_W-1:0] d);
        line_addr_i = la; dout_i = d; rdy = 1'b1;
        cyc();
        rdy = 1'b0;
    endtask

    // Full-mask request n: lane i reads word i%16 of its own line, whose word k holds n*256+k
    task automatic build_full(input int n, output logic [NL*AW-1:0] a, output logic [LINE_W-1:0] d,
                              output logic [31:0] e [NL]);
        for (int i = 0; i < NL; i++) begin
            a[i*AW +: AW] = 32'h0010_0000 + 32'(n*64) + 32'(4*(i%16));
            e[i] = 32'(n*256 + i%16);
        end
        for (int k = 0; k < 16; k++) d[32*k +: 32] = 32'(n*256 + k);
    endtask

    logic [NL*AW-1:0]  a1, a2, af, af5;
    logic [LINE_W-1:0] d1, d2, df, df5;
    logic [31:0]       e1 [NL];
    logic [31:0]       e2 [NL];
    logic [31:0]       ef [NL];
    logic [31:0]       ef5 [NL];
    logic [31:0]       ez [NL];
    logic [NL-1:0]     m1;
    int                L1 [8];

    initial begin
        load_i = 0; rdy = 0; stall_i = 0; reset = 1;
        InfoRamAddr_i = '0; lane_mask_i = '0; RAM2DDR3_ldstWarp_i = '0; RAM2DDR3_ldstReg_i = '0;
        line_addr_i = '0; dout_i = '0;
        L1 = '{5, 6, 8, 15, 16, 17, 28, 31};
        m1 = 32'h9003_8160;
        for (int i = 0; i < NL; i++) begin
            a1[i*AW +: AW] = $urandom;
            e1[i] = 32'd0;
            ez[i] = 32'd0;
        end
        d1 = '0;
        for (int k = 0; k < 8; k++) begin
            a1[L1[k]*AW +: AW] = 32'h0022_CC40 + 32'(4*k);
            e1[L1[k]] = 32'(k);
            d1[32*k +: 32] = 32'(k);
        end
        a2 = a1;
        a2[28*AW +: AW] = 32'h0022_CC80;
        a2[31*AW +: AW] = 32'h0022_CC84;
        e2 = e1;
        e2[28] = 32'hA;
        e2[31] = 32'hB;
        d2 = '0;
        d2[31:0]  = 32'hA;
        d2[63:32] = 32'hB;

        // Reset state
        do_reset();
        check("rst_valid", 64'(loadPacketValid_o), 64'd0);
        check("rst_req_ready", 64'(req_ready_o), 64'd1);
        check("rst_line_ready", 64'(line_ready_o), 64'd0);
        check("rst_drop_err", 64'(drop_err_o), 64'd0);
        check("rst_warp", 64'(loadWarp_o), 64'd0);
        check("rst_mask", 64'(loadMask_o), 64'd0);
        check("rst_pkt_nz", 64'(loadPacket_o != '0), 64'd0);

        // Single-line gather
        send_req(a1, m1, 2'd2, 5'd9);
        check("single_line_ready", 64'(line_ready_o), 64'd1);
        check("single_early_valid", 64'(loadPacketValid_o), 64'd0);
        send_beat(32'h0022_CC40, d1);
        check_pkt("single", 2'd2, m1, 5'd9, e1);
        cyc();
        check("single_drop_valid", 64'(loadPacketValid_o), 64'd0);

        // Split across two lines
        send_req(a2, m1, 2'd2, 5'd9);
        send_beat(32'h0022_CC40, d1);
        check("split_first_valid", 64'(loadPacketValid_o), 64'd0);
        check("split_first_ready", 64'(line_ready_o), 64'd1);
        send_beat(32'h0022_CC80, d2);
        check_pkt("split", 2'd2, m1, 5'd9, e2);
        cyc();

        // Stall holds outputs and blocks beats
        send_req(a1, m1, 2'd2, 5'd9);
        stall_i = 1'b1;
        send_beat(32'h0022_CC40, d1);
        check_pkt("stall", 2'd2, m1, 5'd9, e1);
        check("stall_drop_err_pre", 64'(drop_err_o), 64'd0);
        for (int t = 0; t < 3; t++) begin
            check("stall_line_ready", 64'(line_ready_o), 64'd0);
            check("stall_valid", 64'(loadPacketValid_o), 64'd1);
            check("stall_lane31", 64'(lane(31)), 64'({5'd9, 32'd7}));
            check("stall_mask", 64'(loadMask_o), 64'(m1));
            if (t == 1) begin
                line_addr_i = 32'h0022_CC40; dout_i = d1; rdy = 1'b1;
            end
            cyc();
            rdy = 1'b0;
        end
        check("stall_drop_err", 64'(drop_err_o), 64'd1);
        check("stall_valid_end", 64'(loadPacketValid_o), 64'd1);
        stall_i = 1'b0;
        cyc();
        check("stall_release_valid", 64'(loadPacketValid_o), 64'd0);

        // FIFO full, ignored push, push+pop in one cycle, in-order drain
        do_reset();
        for (int n = 1; n <= 4; n++) begin
            build_full(n, af, df, ef);
            InfoRamAddr_i = af; lane_mask_i = '1; RAM2DDR3_ldstWarp_i = WW'(n); RAM2DDR3_ldstReg_i = RW'(n);
            load_i = 1'b1;
            cyc();
        end
        load_i = 1'b0;
        check("full_req_ready", 64'(req_ready_o), 64'd0);
        build_full(5, af5, df5, ef5);
        send_req(af5, '1, 2'd1, 5'd5);
        check("full_ignored_ready", 64'(req_ready_o), 64'd0);
        check("full_ignored_valid", 64'(loadPacketValid_o), 64'd0);
        build_full(1, af, df, ef);
        send_beat(32'h0010_0000 + 32'd64, df);
        check_pkt("full_pkt1", 2'd1, '1, 5'd1, ef);
        check("full_after_pop_ready", 64'(req_ready_o), 64'd1);
        build_full(2, af, df, ef);
        InfoRamAddr_i = af5; lane_mask_i = '1; RAM2DDR3_ldstWarp_i = 2'd1; RAM2DDR3_ldstReg_i = 5'd5;
        load_i = 1'b1;
        send_beat(32'h0010_0000 + 32'd128, df);
        load_i = 1'b0;
        check_pkt("full_pkt2", 2'd2, '1, 5'd2, ef);
        check("full_pushpop_ready", 64'(req_ready_o), 64'd1);
        build_full(6, af, df, ef);
        send_req(af, '1, 2'd2, 5'd6);
        check("full_again_ready", 64'(req_ready_o), 64'd0);
        for (int n = 3; n <= 6; n++) begin
            build_full(n, af, df, ef);
            send_beat(32'h0010_0000 + 32'(n*64), df);
            check_pkt($sformatf("full_pkt%0d", n), WW'(n), '1, RW'(n), ef);
        end
        cyc();

        // Two back-to-back zero-mask requests
        send_req(a1, '0, 2'd1, 5'd3);
        send_req(a1, '0, 2'd3, 5'd4);
        check_pkt("zero_a", 2'd1, '0, 5'd3, ez);
        cyc();
        check_pkt("zero_b", 2'd3, '0, 5'd4, ez);
        cyc();
        check("zero_drop_valid", 64'(loadPacketValid_o), 64'd0);

        // Beat with nothing queued sets the sticky error
        line_addr_i = 32'h0022_CC40; dout_i = d1;
        rdy = 1'b1;
        cyc();
        rdy = 1'b0;
        check("idle_drop_err", 64'(drop_err_o), 64'd1);

        // Reset in the middle of a two-beat gather
        send_req(a2, m1, 2'd2, 5'd9);
        send_beat(32'h0022_CC40, d1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("midrst_valid", 64'(loadPacketValid_o), 64'd0);
        check("midrst_req_ready", 64'(req_ready_o), 64'd1);
        check("midrst_line_ready", 64'(line_ready_o), 64'd0);
        check("midrst_drop_err", 64'(drop_err_o), 64'd0);
        check("midrst_mask", 64'(loadMask_o), 64'd0);
        send_req(a1, m1, 2'd1, 5'd17);
        send_beat(32'h0022_CC40, d1);
        check_pkt("midrst_fresh", 2'd1, m1, 5'd17, e1);
        cyc();

        // Randomized traffic against the reference memory model
        do_reset();
        begin
            int   sent;
            int   cycles;
            req_t r;
            req_t x;
            sent = 0;
            cycles = 0;
            while ((sent < N_RND || exp_q.size() != 0) && cycles < BUDGET) begin
                @(posedge clk);
                #1;
                cycles++;
                load_i = 1'b0;
                rdy = 1'b0;
                stall_i = ($urandom_range(0, 3) == 0);
                if (sent < N_RND && req_ready_o && $urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 3))
                        0:       r.mask = '0;
                        1:       r.mask = '1;
                        default: r.mask = $urandom;
                    endcase
                    for (int i = 0; i < NL; i++)
                        r.addrs[i*AW +: AW] = POOL + 32'($urandom_range(0, 7) * 64) + 32'($urandom_range(0, 63));
                    r.warp = WW'($urandom);
                    r.rg   = RW'($urandom);
                    InfoRamAddr_i = r.addrs; lane_mask_i = r.mask;
                    RAM2DDR3_ldstWarp_i = r.warp; RAM2DDR3_ldstReg_i = r.rg;
                    load_i = 1'b1;
                    exp_q.push_back(r);
                    sent++;
                end
                #1;
                if (line_ready_o && $urandom_range(0, 2) != 0) begin
                    // index 8 is a line no request uses
                    line_addr_i = POOL + 32'($urandom_range(0, 8) * 64) + 32'($urandom_range(0, 63));
                    dout_i = line_data(line_addr_i);
                    rdy = 1'b1;
                end
                @(negedge clk);
                if (loadPacketValid_o && !stall_i) begin
                    if (exp_q.size() == 0) begin
                        check("rnd_spurious_valid", 64'd1, 64'd0);
                    end else begin
                        x = exp_q.pop_front();
                        check("rnd_warp", 64'(loadWarp_o), 64'(x.warp));
                        check("rnd_mask", 64'(loadMask_o), 64'(x.mask));
                        for (int i = 0; i < NL; i++)
                            check($sformatf("rnd_lane%0d", i), 64'(lane(i)),
                                  64'({x.rg, x.mask[i] ? mem_word(x.addrs[i*AW +: AW]) : 32'd0}));
                    end
                end
            end
            if (cycles >= BUDGET)
                check("rnd_timeout_outstanding", 64'(exp_q.size()), 64'd0);
            check("rnd_sent", 64'(sent), 64'(N_RND));
            load_i = 1'b0;
            rdy = 1'b0;
            stall_i = 1'b0;
            check("rnd_drop_err", 64'(drop_err_o), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
